// File: rtl/wb_rambus_arbiter.sv
// Round-robin arbiter sharing rambus Wishbone port B between N_REQ masters.
// A per-transaction watchdog terminates strobes left unacknowledged with an err pulse.
module wb_rambus_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [N_REQ-1:0]    req_en_i,
  input  logic [N_REQ-1:0]    m_cyc_i,
  input  logic [N_REQ-1:0]    m_stb_i,
  input  logic [N_REQ-1:0]    m_we_i,
  input  logic [4*N_REQ-1:0]  m_sel_i,
  input  logic [32*N_REQ-1:0] m_dat_i,
  input  logic [10*N_REQ-1:0] m_adr_i,
  output logic [N_REQ-1:0]    m_ack_o,
  output logic [N_REQ-1:0]    m_err_o,
  output logic [31:0]         m_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [3:0]          s_sel_o,
  output logic [31:0]         s_dat_o,
  output logic [9:0]          s_adr_o,
  input  logic                s_ack_i,
  input  logic [31:0]         s_dat_i,
  output logic [N_REQ-1:0]    grant_o,
  output logic                busy_o,
  output logic [7:0]          timeouts_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [15:0]      wdog_q, wdog_d;
  logic [7:0]       tmo_q, tmo_d;

  logic [N_REQ-1:0] cand_s;
  logic             pick_vld_s;
  logic [IW-1:0]    pick_s;
  logic [IW-1:0]    scan_idx_s;
  logic             live_s;

  logic [3:0]  sel_arr_s [N_REQ];
  logic [31:0] dat_arr_s [N_REQ];
  logic [9:0]  adr_arr_s [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign sel_arr_s[i] = m_sel_i[4*i +: 4];
    assign dat_arr_s[i] = m_dat_i[32*i +: 32];
    assign adr_arr_s[i] = m_adr_i[10*i +: 10];
  end

  assign cand_s = m_cyc_i & req_en_i;
  // The owner stays live only while it holds cyc and remains enabled.
  assign live_s = m_cyc_i[owner_q] & req_en_i[owner_q];

  // Rotating-priority pick: first candidate scanning upward from last+1.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = '0;
    scan_idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx_s = IW'((int'(last_q) + 1 + k) % N_REQ);
      if (!pick_vld_s && cand_s[scan_idx_s]) begin
        pick_vld_s = 1'b1;
        pick_s     = scan_idx_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // FSM next-state, watchdog, and the combinational bus mux toward the RAM.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_dat_o = 32'h0;
    s_adr_o = 10'h0;
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_d         = ST_GRANT;
          owner_d         = pick_s;
          grant_d         = '0;
          grant_d[pick_s] = 1'b1;
          wdog_d          = 16'd0;
        end else begin
          grant_d = '0;
        end
      end
      ST_GRANT: begin
        s_cyc_o          = live_s;
        s_stb_o          = live_s & m_stb_i[owner_q];
        s_we_o           = m_we_i[owner_q];
        s_sel_o          = sel_arr_s[owner_q];
        s_dat_o          = dat_arr_s[owner_q];
        s_adr_o          = adr_arr_s[owner_q];
        m_ack_o[owner_q] = s_ack_i & live_s;
        if (!live_s) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end else if (s_ack_i) begin
          wdog_d = 16'd0;
        end else if (s_stb_o) begin
          if (wdog_q == 16'(TIMEOUT - 1)) begin
            state_d = ST_ERR;
            wdog_d  = 16'd0;
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
        end else begin
          wdog_d = wdog_q;
        end
      end
      ST_ERR: begin
        m_err_o[owner_q] = 1'b1;
        state_d          = ST_IDLE;
        last_d           = owner_q;
        grant_d          = '0;
        if (tmo_q != 8'hFF) begin
          tmo_d = tmo_q + 8'd1;
        end else begin
          tmo_d = tmo_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        wdog_d  = 16'd0;
      end
    endcase
  end

  // State registers; last resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      grant_q <= '0;
      wdog_q  <= 16'd0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  assign m_dat_o    = s_dat_i;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign timeouts_o = tmo_q;

endmodule

// File: tb/tb_wb_rambus_arbiter.sv
// Bench for wb_rambus_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_wb_rambus_arbiter;
  localparam int N   = 4;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_en, m_cyc, m_stb, m_we;
  logic [3:0]  mst_sel [4];
  logic [31:0] mst_dat [4];
  logic [9:0]  mst_adr [4];
  logic [15:0] m_sel;
  logic [127:0] m_dat;
  logic [39:0] m_adr;
  logic [3:0]  m_ack, m_err, grant;
  logic [31:0] m_dato, s_dat, s_dati;
  logic        s_cyc, s_stb, s_we, s_ack, busy;
  logic [3:0]  s_sel;
  logic [9:0]  s_adr;
  logic [7:0]  timeouts;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign m_sel[4*i +: 4]   = mst_sel[i];
    assign m_dat[32*i +: 32] = mst_dat[i];
    assign m_adr[10*i +: 10] = mst_adr[i];
  end

  wb_rambus_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_en_i(req_en),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_dat_i(m_dat), .m_adr_i(m_adr),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dato),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_dat_o(s_dat), .s_adr_o(s_adr),
    .s_ack_i(s_ack), .s_dat_i(s_dati),
    .grant_o(grant), .busy_o(busy), .timeouts_o(timeouts)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] ram [1024];

  bit          md_busy, md_err;
  logic [1:0]  md_own, md_last;
  int          md_wd, md_tmo;

  logic [3:0]  obs_ack, obs_err, obs_grant, prev_g;
  logic        obs_cyc, obs_busy;
  logic [31:0] obs_mdat;
  logic [3:0]  gseq [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    req_en = 4'b1111; m_cyc = 4'b0; m_stb = 4'b0; m_we = 4'b0;
    s_ack = 1'b0; s_dati = 32'h0;
    for (int i = 0; i < N; i++) begin
      mst_sel[2'(i)] = 4'h0; mst_dat[2'(i)] = 32'h0; mst_adr[2'(i)] = 10'h0;
    end
  endtask

  task automatic model_reset();
    md_busy = 1'b0; md_err = 1'b0; md_own = 2'd0; md_last = 2'd3; md_wd = 0; md_tmo = 0;
  endtask

  // One clock: check all outputs against the model, then advance the model at the edge.
  task automatic cycle();
    logic live, e_cyc, e_stb, e_we, found;
    logic [3:0] e_ack, e_err, e_grant, e_sel, cand;
    logic [31:0] e_dat;
    logic [9:0] e_adr;
    logic [1:0] idx;
    #1;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_dat = 32'h0; e_adr = 10'h0;
    e_ack = 4'h0; e_err = 4'h0;
    live = md_busy && !md_err && m_cyc[md_own] && req_en[md_own];
    e_grant = md_busy ? (4'b0001 << md_own) : 4'b0000;
    if (md_busy && md_err) e_err[md_own] = 1'b1;
    if (md_busy && !md_err) begin
      e_cyc = live; e_stb = live & m_stb[md_own]; e_we = m_we[md_own];
      e_sel = mst_sel[md_own]; e_dat = mst_dat[md_own]; e_adr = mst_adr[md_own];
      e_ack[md_own] = live & s_ack;
    end
    check_eq("s_cyc", 32'(s_cyc), 32'(e_cyc));
    check_eq("s_stb", 32'(s_stb), 32'(e_stb));
    check_eq("s_we", 32'(s_we), 32'(e_we));
    check_eq("s_sel", 32'(s_sel), 32'(e_sel));
    check_eq("s_dat", s_dat, e_dat);
    check_eq("s_adr", 32'(s_adr), 32'(e_adr));
    check_eq("m_ack", 32'(m_ack), 32'(e_ack));
    check_eq("m_err", 32'(m_err), 32'(e_err));
    check_eq("m_dat", m_dato, s_dati);
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("busy", 32'(busy), 32'(md_busy));
    check_eq("timeouts", 32'(timeouts), 32'(md_tmo));
    if (s_cyc && s_stb && s_we && s_ack) ram[s_adr] = s_dat;
    obs_ack = m_ack; obs_err = m_err; obs_grant = grant;
    obs_cyc = s_cyc; obs_busy = busy; obs_mdat = m_dato;
    @(posedge clk);
    if (!md_busy) begin
      cand = m_cyc & req_en;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = md_last + 2'(k + 1);
        if (!found && cand[idx]) begin found = 1'b1; md_own = idx; end
      end
      if (found) begin md_busy = 1'b1; md_wd = 0; end
    end else if (md_err) begin
      if (md_tmo < 255) md_tmo++;
      md_last = md_own; md_busy = 1'b0; md_err = 1'b0;
    end else if (!live) begin
      md_last = md_own; md_busy = 1'b0;
    end else if (s_ack) begin
      md_wd = 0;
    end else if (m_stb[md_own]) begin
      md_wd++;
      if (md_wd == TMO) begin md_err = 1'b1; md_wd = 0; end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset in mid-cycle: outputs must clear without a clock edge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_s_cyc", 32'(s_cyc), 32'd0);
    check_eq("rst_s_stb", 32'(s_stb), 32'd0);
    check_eq("rst_ack", 32'(m_ack), 32'd0);
    check_eq("rst_err", 32'(m_err), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_tmo", 32'(timeouts), 32'd0);
    model_reset();
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic track_grant();
    if (obs_grant != 4'b0 && obs_grant != prev_g) gseq.push_back(obs_grant);
    prev_g = obs_grant;
  endtask

  initial begin
    int err_n, err_at;
    logic [3:0] any_g;
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single master write then read-back
    m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
    mst_adr[0] = 10'h010; mst_dat[0] = 32'hA5A55A5A; mst_sel[0] = 4'hF;
    cycle();
    s_ack = 1'b1;
    cycle();
    check_eq("sm_grant", 32'(obs_grant), 32'h1);
    check_eq("sm_wr_ack", 32'(obs_ack), 32'h1);
    m_cyc = 4'b0; m_stb = 4'b0; m_we = 4'b0; s_ack = 1'b0;
    cycle();
    cycle();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    cycle();
    s_ack = 1'b1; s_dati = ram[10'h010];
    cycle();
    check_eq("sm_rd_ack", 32'(obs_ack), 32'h1);
    check_eq("sm_rdata", obs_mdat, 32'hA5A55A5A);

    // Simultaneous requests from all four masters
    do_reset();
    gseq.delete(); prev_g = 4'b0;
    m_cyc = 4'b1111; m_stb = 4'b1111; s_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle(); track_grant();
      m_cyc = m_cyc & ~obs_ack; m_stb = m_cyc;
    end
    check_eq("rr_len", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("rr_order", (i < gseq.size()) ? 32'(gseq[i]) : 32'h0, 32'(4'b0001 << i));

    // Fairness between repeated masters 1 and 2
    do_reset();
    gseq.delete(); prev_g = 4'b0;
    m_cyc = 4'b0110; m_stb = 4'b0110; s_ack = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle(); track_grant();
      m_cyc = 4'b0110 & ~obs_ack; m_stb = m_cyc;
    end
    check_eq("fair_len", 32'(gseq.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      check_eq("fair_order", (i < gseq.size()) ? 32'(gseq[i]) : 32'h0,
               (i % 2 == 0) ? 32'h2 : 32'h4);

    // Enable gating: disabled master 0 never granted
    do_reset();
    req_en = 4'b1110; m_cyc = 4'b0001; m_stb = 4'b0001;
    any_g = 4'b0;
    for (int i = 0; i < 10; i++) begin cycle(); any_g = any_g | obs_grant; end
    check_eq("en_gate0", 32'(any_g), 32'h0);

    // Enable dropped while master 2 owns the bus
    req_en = 4'b1111; m_cyc = 4'b0100; m_stb = 4'b0100;
    cycle();
    cycle();
    check_eq("en2_grant", 32'(obs_grant), 32'h4);
    req_en = 4'b1011; s_ack = 1'b1;
    cycle();
    check_eq("en2_cyc", 32'(obs_cyc), 32'h0);
    check_eq("en2_ack", 32'(obs_ack), 32'h0);
    check_eq("en2_err", 32'(obs_err), 32'h0);
    cycle();
    check_eq("en2_idle", 32'(obs_busy), 32'h0);

    // Watchdog on master 3 with a RAM that never acks
    do_reset();
    m_cyc = 4'b1000; m_stb = 4'b1000;
    err_n = 0; err_at = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_err[3]) begin err_n++; err_at = i; end
    end
    check_eq("wd_err_count", 32'(err_n), 32'd1);
    check_eq("wd_err_cycle", 32'(err_at), 32'd5);
    check_eq("wd_tmo_one", 32'(timeouts), 32'd1);
    for (int i = 0; i < 1800; i++) cycle();
    check_eq("wd_tmo_sat", 32'(timeouts), 32'd255);

    // Reset while master 1 waits on ack
    m_cyc = 4'b0010; m_stb = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_grant == 4'b0010) break;
    end
    check_eq("mid_grant", 32'(obs_grant), 32'h2);
    do_reset();
    m_cyc = 4'b0011; m_stb = 4'b0011;
    cycle();
    cycle();
    check_eq("post_rst_prio", 32'(obs_grant), 32'h1);

    // Random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) m_cyc[2'(i)] = ~m_cyc[2'(i)];
        m_stb[2'(i)] = m_cyc[2'(i)] & 1'($urandom_range(1));
        m_we[2'(i)] = 1'($urandom_range(1));
        mst_sel[2'(i)] = 4'($urandom);
        mst_dat[2'(i)] = $urandom;
        mst_adr[2'(i)] = 10'($urandom);
        if ($urandom_range(31) == 0) req_en[2'(i)] = ~req_en[2'(i)];
      end
      s_ack = ($urandom_range(2) == 0);
      s_dati = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_rambus_arbiter.md
# wb_rambus_arbiter

Round-robin arbiter sharing the single Wishbone port B of the dual-port OpenRAM wrapper (rambus: 10-bit address, 32-bit data, byte selects) between up to `N_REQ` user-project masters. It sits in `user_project_wrapper` between the user projects' `rambus_wb_*` master ports and the wrapper's `wbs_b_*` slave port. It also provides a per-transaction watchdog that terminates stalled cycles with an error pulse. Requesters are gated by their `active` bits, so a disabled project can never own the RAM.

## Interface
Parameters:
- `N_REQ`, 4, number of requesting masters (1..8)
- `TIMEOUT`, 255, cycles a strobe may wait for ack before error termination (1..65535)

Ports:
- `wb_clk_i`  in  1  clock; the same clock drives all masters and the RAM port
- `wb_rst_ni`  in  1  asynchronous, active-low reset
- `req_en_i`  in  N_REQ  per-requester enable (from `active` bits); 0 = never granted
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  N_REQ each  master cycle, strobe and write-enable
- `m_sel_i`  in  4*N_REQ  byte selects; requester i is at [4i+3:4i]
- `m_dat_i`  in  32*N_REQ  write data
- `m_adr_i`  in  10*N_REQ  word address
- `m_ack_o`, `m_err_o`  out  N_REQ each  per-master ack and error
- `m_dat_o`  out  32  read data, broadcast to all masters (qualified by ack)
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to RAM wrapper port B
- `s_sel_o` out 4; `s_dat_o` out 32; `s_adr_o` out 10  to RAM wrapper port B
- `s_ack_i`  in  1  ack from RAM wrapper; `s_dat_i`  in  32  read data
- `grant_o`  out  N_REQ  one-hot registered grant; all zero when idle
- `busy_o`  out  1  state != IDLE
- `timeouts_o`  out  8  saturating count of watchdog terminations

## Operation
- States: IDLE, GRANT, ERR.
- IDLE: `s_*` outputs are 0 and all `m_ack_o`/`m_err_o` are 0. Candidates are `m_cyc_i & req_en_i`. If any candidate is set, select the first one scanning upward from `last+1` (mod N_REQ), register it into `grant_o`, clear the watchdog and go to GRANT.
- GRANT, owner g:
  - `s_cyc_o = m_cyc_i[g]`; `s_stb_o = m_stb_i[g]`.
  - `s_we_o`, `s_sel_o`, `s_dat_o` and `s_adr_o` are muxed combinationally from g.
  - `m_ack_o[g] = s_ack_i`; all other acks are 0. `m_dat_o = s_dat_i`.
- Watchdog: increments each cycle with `s_stb_o & ~s_ack_i` and clears on `s_ack_i`. When it reaches TIMEOUT with still no ack, go to ERR.
- ERR (exactly 1 cycle):
  - `m_err_o[g]=1`; `s_cyc_o`, `s_stb_o` and all acks forced 0.
  - `timeouts_o` increments, saturating at 255.
  - Then go to IDLE with `last=g`.
- Release: in GRANT, if `m_cyc_i[g]==0` or `req_en_i[g]==0`, go to IDLE with `last=g`. The `s_*` outputs follow `m_cyc_i[g]` combinationally, so the RAM sees cyc drop in the same cycle.
- Disable mid-transaction (`req_en_i[g]` falls):
  - `s_cyc_o` and `s_stb_o` are forced 0 in that cycle.
  - No ack or err is delivered to g.
- Every grant is followed by at least one IDLE cycle. Back-to-back bursts from one master therefore lose one cycle, which guarantees rotation.
- Non-owner masters see ack=err=0 and must wait. Their cyc may stay high indefinitely.
- Reset values:
  - state IDLE; `grant_o=0`; `busy_o=0`; `timeouts_o=0`; watchdog 0.
  - `last=N_REQ-1`, so requester 0 has first priority.
  - All `s_*` and `m_ack_o`/`m_err_o` are 0.
- Reset assertion mid-transaction immediately returns the block to IDLE with all outputs 0.

## Timing
- Arbitration latency: cyc sampled high at edge n → `grant_o` and `s_cyc_o` high after edge n (1 cycle).
- Ack path `s_ack_i` → `m_ack_o[g]` is combinational (0 added latency). The RAM wrapper's own read latency is preserved.
- Release: `m_cyc_i[g]` low at edge k → IDLE after k. The earliest new grant is after edge k+1.
- Error: stb waiting with no ack for TIMEOUT consecutive cycles → `m_err_o` is high for the single following cycle.
- Simultaneous requests are resolved by rotating priority only; ties cannot occur.
- `req_en_i` and `m_cyc_i` are synchronous to `wb_clk_i`.

## Test plan
- Single-master traffic: reset, then requester 0 writes 0xA5A55A5A to address 0x010 and reads it back. Required: `grant_o=0001` one cycle after cyc; `m_ack_o[0]` mirrors the RAM ack; read data equals 0xA5A55A5A.
- Simultaneous requests: masters 0–3 raise cyc in the same cycle, each doing a 1-word transfer and dropping cyc after ack. Required: grants in the order 0,1,2,3, with one IDLE cycle between consecutive grants.
- Fairness: master 1 holds cyc continuously for repeated single transfers while master 2 requests. Required: the grant alternates 1,2,1,2 and master 2 is never starved.
- Enable gating:
  - `req_en_i=1110` with master 0 requesting → never granted.
  - Drop `req_en_i[2]` mid-cycle while 2 owns the bus → `s_cyc_o=0` in that same cycle, IDLE next cycle, no ack or err to master 2.
- Watchdog: stub the RAM with `s_ack_i` tied 0 and TIMEOUT=4; master 3 strobes. Required:
  - `m_err_o[3]` is high for exactly 1 cycle, 4 cycles after the strobe began.
  - `timeouts_o` goes 0→1; saturation holds at 255 after 300 repeats.
- Reset mid-operation: assert `wb_rst_ni=0` while master 1 is granted and waiting on ack. Required: all outputs go 0 asynchronously; after release, requester 0 has priority again.
